// File: rtl/timer_irq_servicer_if.sv
// Requester-side valid/ready memory bus shared with the timer MMIO block.
// master = initiator (servicer), slave = responder (timer via arbiter).
interface timer_irq_servicer_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/timer_irq_servicer.sv
// Services timer irqs: read STATUS, W1C pending causes, pulse eoi, tally per cause.
// Requests hold until mem_ready; each transfer aborts after TIMEOUT_CYCLES (eoi still sent).
module timer_irq_servicer #(
  parameter logic [31:0] TIMER_BASE     = 32'h8100_7000,
  parameter int unsigned CNT_W          = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd64,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 timer_irq_i,
  output logic                 eoi_o,
  timer_irq_servicer_if.master bus,
  output logic [CNT_W-1:0]     compare_count_o,
  output logic [CNT_W-1:0]     overflow_count_o,
  output logic [CNT_W-1:0]     prescaler_count_o,
  output logic [CNT_W-1:0]     spurious_count_o,
  output logic [3:0]           last_status_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);
  localparam logic [31:0] STATUS_ADDR = TIMER_BASE + 32'h10;
  localparam int unsigned HOLD_W      = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, EOI, HOLD} state_e;

  state_e             state_q;
  logic [31:0]        tmo_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               mem_valid_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [3:0]         mem_wstrb_q;
  logic               eoi_q;
  logic [CNT_W-1:0]   cmp_q, ovf_q, pre_q, spur_q;
  logic [3:0]         last_q;
  logic               busy_q;
  logic               terr_q;
  logic               tmo_hit;
  logic               unused_rdata;

  assign tmo_hit      = (tmo_q == TIMEOUT_CYCLES - 32'd1);
  // Only STATUS[3:0] carries meaning.
  assign unused_rdata = ^bus.mem_rdata[31:4];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      hold_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      eoi_q       <= 1'b0;
      cmp_q       <= '0;
      ovf_q       <= '0;
      pre_q       <= '0;
      spur_q      <= '0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      eoi_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && timer_irq_i) begin
            state_q     <= RD_REQ;
            busy_q      <= 1'b1;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= STATUS_ADDR;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            tmo_q       <= '0;
          end
        end
        RD_REQ, WR_REQ: begin
          if (bus.mem_ready) begin
            tmo_q <= '0;
            if (state_q == RD_REQ) begin
              last_q <= bus.mem_rdata[3:0];
              cmp_q  <= sat_inc(cmp_q, bus.mem_rdata[0]);
              ovf_q  <= sat_inc(ovf_q, bus.mem_rdata[1]);
              pre_q  <= sat_inc(pre_q, bus.mem_rdata[2]);
            end
            if (state_q == RD_REQ && bus.mem_rdata[2:0] != 3'b000) begin
              // W1C only the event bits; bit3 (run) is left untouched.
              state_q     <= WR_REQ;
              mem_wdata_q <= {29'd0, bus.mem_rdata[2:0]};
              mem_wstrb_q <= 4'b0001;
            end else begin
              if (state_q == RD_REQ) spur_q <= sat_inc(spur_q, 1'b1);
              state_q     <= EOI;
              eoi_q       <= 1'b1;
              mem_valid_q <= 1'b0;
              mem_wstrb_q <= '0;
            end
          end else if (tmo_hit) begin
            state_q     <= EOI;
            eoi_q       <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            terr_q      <= 1'b1;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        EOI: begin
          state_q <= HOLD;
          hold_q  <= HOLD_W'(HOLDOFF_CYCLES);
        end
        HOLD: begin
          if (hold_q <= HOLD_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_instr     = 1'b0;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign eoi_o             = eoi_q;
  assign compare_count_o   = cmp_q;
  assign overflow_count_o  = ovf_q;
  assign prescaler_count_o = pre_q;
  assign spurious_count_o  = spur_q;
  assign last_status_o     = last_q;
  assign busy_o            = busy_q;
  assign timeout_err_o     = terr_q;
endmodule

// File: doc/timer_irq_servicer.md
Name: timer_irq_servicer

Overview:
- Bus initiator for the timer MMIO block; drives the same valid/ready memory interface from the requester side.
- Also terminates the timer's irq/eoi pair.
- On timer_irq it reads TIMER_STATUS, write-1-clears the pending event bits, pulses eoi, and tallies events per cause.
- Sits beside the timer, so the CPU need not service every tick; it shares the timer's bus port through an external arbiter.

Parameters:
- TIMER_BASE, 32'h8100_7000, timer MMIO base address. STATUS is at TIMER_BASE+32'h10.
- CNT_W, 16, width of each event counter (1..32).
- TIMEOUT_CYCLES, 32'd64, cycles to wait for mem_ready before aborting a bus transfer (must be ≥2).
- HOLDOFF_CYCLES, 2, cycles after an eoi pulse during which timer_irq is ignored (must be ≥1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  1 = service interrupts. 0 = stay in or return to IDLE once the current transfer ends.
- timer_irq  in  1  level interrupt from timer
- eoi  out  1  one-cycle end-of-interrupt pulse to timer
- mem_valid  out  1  bus request
- mem_instr  out  1  tied 0
- mem_ready  in  1  bus acknowledge
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_rdata  in  32  read data, valid in the mem_ready cycle
- compare_count  out  CNT_W  compare-match events serviced
- overflow_count  out  CNT_W  overflow events serviced
- prescaler_count  out  CNT_W  prescaler-overflow events serviced
- spurious_count  out  CNT_W  irqs with status[2:0]==0
- last_status  out  4  status[3:0] from the most recent read
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  sticky; set on any bus timeout

Behaviour:
- Reset (async, any state):
  - All outputs 0: mem_valid, eoi, counters, last_status, timeout_err.
  - FSM to IDLE; timeout and holdoff counters cleared.
  - A transfer in flight is abandoned.
- All outputs are registered.
- FSM states: IDLE, RD_REQ, WR_REQ, EOI, HOLD.
- IDLE:
  - If enable && timer_irq, go to RD_REQ next cycle.
  - mem_valid=1, mem_addr=TIMER_BASE+0x10, mem_wstrb=0, mem_wdata=0.
- Request hold rule:
  - valid/addr/wdata/wstrb stay stable from assertion until the cycle mem_ready is sampled 1.
  - mem_valid deasserts on the following edge.
  - mem_ready while mem_valid=0 is ignored.
- RD_REQ, on mem_ready:
  - Register last_status <= mem_rdata[3:0].
  - Increment compare_count if bit0, overflow_count if bit1, prescaler_count if bit2. All apply in the same cycle when several bits are set.
  - If mem_rdata[2:0]!=0: go to WR_REQ with mem_wdata={29'd0, mem_rdata[2:0]}, mem_wstrb=4'b0001. Bit3 is never written, so the timer is not stopped.
  - Otherwise: increment spurious_count and go to EOI.
- WR_REQ: on mem_ready, go to EOI.
- EOI:
  - eoi=1 for exactly one cycle; mem_valid=0.
  - Go to HOLD and load the holdoff counter with HOLDOFF_CYCLES.
- HOLD: timer_irq ignored; counts down, then goes to IDLE.
- Counters saturate at all-ones and never wrap.
- Timeout:
  - In RD_REQ/WR_REQ, count cycles since mem_valid rose.
  - If TIMEOUT_CYCLES elapse with no mem_ready: drop mem_valid, set timeout_err, leave counters and last_status unchanged, go to EOI (the irq is still acknowledged).
  - timeout_err clears only on reset.
- enable falling mid-sequence: the current sequence completes through HOLD; no new service starts until enable=1.
- timer_irq deasserting during RD_REQ/WR_REQ has no effect; the sequence completes.
- mem_ready and timeout expiring in the same cycle: mem_ready wins; no error.
- Minimum latency with a 1-cycle-ready responder: irq high at cycle 0 → read valid at 1 → ready at 2 → write valid at 3 → ready at 4 → eoi at 5.

Test Plan:
- Timer responder model, ready 1 cycle after valid, status=0x9: compare_count=1, write addr=0x8100_7010 wdata=0x1 wstrb=0x1, eoi pulse 1 cycle at cycle 5, last_status=0x9.
- status=0xF: compare, overflow and prescaler counts each increment by 1; write wdata=0x7; bit3 never written.
- status=0x8 (spurious): no write issued, spurious_count=1, eoi pulsed.
- Responder never asserts ready, TIMEOUT_CYCLES=64: mem_valid drops after 64 cycles, timeout_err=1, eoi pulses, counters unchanged.
- CNT_W=4, 20 compare irqs: compare_count saturates at 15.
- Reset asserted mid-WR_REQ: mem_valid, eoi and counters go to 0 immediately without a clock edge. After release with irq held, a fresh read starts. enable=0 with irq high → no bus activity.
